// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: round-robin sequencer of register-to-register moves over a shared tri-state bus
module bus_xfer_ctrl #(
  parameter int BITW = 8,
  parameter int NREG = 4,
  parameter int NREQ = 2,
  parameter int SELW = $clog2(NREG + 1),
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [NREQ*SELW-1:0] req_src_i,
  input  logic [NREQ*SELW-1:0] req_dst_i,
  input  logic [NREQ*BITW-1:0] req_imm_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic [NREG-1:0]      rd_en_o,
  output logic [NREG-1:0]      wr_en_o,
  inout  wire  [BITW-1:0]      bus_io,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [IDW-1:0]       done_id_o,
  output logic                 err_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_t;
  localparam logic [SELW-1:0] IMM_SEL = SELW'(NREG);
  state_t          state_q, state_d;
  logic [IDW-1:0]  p_q, p_d, id_q, id_d, gid, idx, done_id_q, done_id_d;
  logic [SELW-1:0] src_q, src_d, dst_q, dst_d, gsrc;
  logic [BITW-1:0] imm_q, imm_d;
  logic [NREG-1:0] rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic            busy_q, busy_d, done_q, done_d, err_q, err_d, found, accept;
  logic [NREQ-1:0] grant;
  // First valid requester scanning from the pointer; no grants in ISSUE or under reset.
  always_comb begin
    grant = '0;
    gid   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(p_q) + 32'(k)) % NREQ);
      if (!found && req_valid_i[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gid        = idx;
      end
    end
    if (reset_i || state_q == ISSUE) grant = '0;
  end
  assign accept      = |grant;
  assign req_ready_o = grant;
  assign gsrc        = req_src_i[gid*SELW +: SELW];
  always_comb begin
    state_d   = state_q;
    p_d       = accept ? ((32'(gid) == NREQ - 1) ? '0 : gid + 1'b1) : p_q;
    id_d      = accept ? gid : id_q;
    src_d     = accept ? gsrc : src_q;
    dst_d     = accept ? req_dst_i[gid*SELW +: SELW] : dst_q;
    imm_d     = accept ? req_imm_i[gid*BITW +: BITW] : imm_q;
    rd_en_d   = (accept && gsrc < IMM_SEL) ? NREG'(1) << gsrc : '0;
    wr_en_d   = (state_q == ISSUE && dst_q < IMM_SEL) ? NREG'(1) << dst_q : '0;
    done_d    = state_q == XFER;
    err_d     = state_q == XFER && dst_q >= IMM_SEL;
    done_id_d = state_q == XFER ? id_q : done_id_q;
    if (state_q == IDLE) state_d = accept ? ISSUE : IDLE;
    else if (state_q == ISSUE) state_d = XFER;
    else state_d = accept ? ISSUE : IDLE;
    busy_d    = state_d != IDLE;
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      p_q       <= '0;
      id_q      <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      imm_q     <= '0;
      rd_en_q   <= '0;
      wr_en_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      id_q      <= id_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      imm_q     <= imm_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      done_id_q <= done_id_d;
    end
  end
  assign bus_io    = (state_q == XFER && src_q == IMM_SEL) ? imm_q : 'z;
  assign rd_en_o   = rd_en_q;
  assign wr_en_o   = wr_en_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign done_id_o = done_id_q;
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb_bus_xfer_ctrl: directed bench for bus_xfer_ctrl with a model of four bus registers
module tb_bus_xfer_ctrl;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req_valid = '0;
  logic [5:0] req_src = '0;
  logic [5:0] req_dst = '0;
  logic [15:0] req_imm = '0;
  logic [1:0] req_ready;
  logic [3:0] rd_en, wr_en, rd_d;
  wire  [7:0] bus;
  logic       busy, done, err, done_id, imm1, imm2;
  logic [7:0] regs [4];
  logic [2:0] gsrc;
  int checks = 0, failures = 0;

  bus_xfer_ctrl dut (
    .clock_i(clock), .reset_i(reset), .req_valid_i(req_valid), .req_src_i(req_src),
    .req_dst_i(req_dst), .req_imm_i(req_imm), .req_ready_o(req_ready), .rd_en_o(rd_en),
    .wr_en_o(wr_en), .bus_io(bus), .busy_o(busy), .done_o(done), .done_id_o(done_id), .err_o(err)
  );

  always #5 clock = ~clock;

  // Bus register model: drives the bus the cycle after rd_en, captures on wr_en.
  assign bus = rd_d[0] ? regs[0] : rd_d[1] ? regs[1] : rd_d[2] ? regs[2] : rd_d[3] ? regs[3] : 'z;
  assign gsrc = req_ready[1] ? req_src[5:3] : req_src[2:0];
  always @(posedge clock) begin
    if (reset) begin
      regs[0] <= 8'h10; regs[1] <= 8'h5A; regs[2] <= 8'h22; regs[3] <= 8'h33;
      rd_d <= '0; imm1 <= 1'b0; imm2 <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) if (wr_en[k]) regs[k] <= bus;
      rd_d <= rd_en;
      imm1 <= (|(req_valid & req_ready)) && gsrc == 3'd4;
      imm2 <= imm1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) if (!reset) begin
    check("rd_wr_same_reg", 32'(rd_en & wr_en), 0);
    check("one_bus_driver", 32'($countones(rd_d) + 32'(imm2) <= 1), 1);
    check("ready_onehot", 32'($countones(req_ready) <= 1), 1);
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req_valid = '0;
    repeat (2) step;
    reset = 1'b0;
  endtask

  task automatic do_move(input int id, input int src, input int dst, input logic [7:0] imm,
                         input logic [7:0] val);
    req_src[id*3 +: 3] = 3'(src);
    req_dst[id*3 +: 3] = 3'(dst);
    req_imm[id*8 +: 8] = imm;
    req_valid = '0;
    req_valid[id] = 1'b1;
    #1;
    check("accept_ready", 32'(req_ready), 32'(1 << id));
    step;
    req_valid = '0;
    check("issue_rd", 32'(rd_en), src < 4 ? 32'(1 << src) : 0);
    check("issue_wr", 32'(wr_en), 0);
    check("issue_busy", 32'(busy), 1);
    step;
    check("xfer_wr", 32'(wr_en), dst < 4 ? 32'(1 << dst) : 0);
    check("xfer_rd", 32'(rd_en), 0);
    check("xfer_bus", 32'(bus), 32'(val));
    step;
    check("done", 32'(done), 1);
    check("done_id", 32'(done_id), 32'(id));
    check("err", 32'(err), dst >= 4 ? 1 : 0);
    if (dst < 4) check("dest_value", 32'(regs[dst]), 32'(val));
    step;
    check("done_pulse", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    req_valid = 2'b11;
    repeat (2) step;
    check("rst_ready", 32'(req_ready), 0);
    check("rst_rd", 32'(rd_en), 0);
    check("rst_wr", 32'(wr_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    req_valid = '0;
    reset = 1'b0;
    do_move(0, 1, 2, 8'h00, 8'h5A);
    do_move(0, 4, 0, 8'hC3, 8'hC3);
    do_reset;
    req_src = {3'd4, 3'd1};
    req_dst = {3'd2, 3'd3};
    req_imm = {8'h77, 8'h00};
    req_valid = 2'b11;
    #1;
    check("rr_first", 32'(req_ready), 1);
    for (int i = 1; i <= 8; i++) begin
      step;
      if (i % 2 == 1) begin
        check("rr_issue_ready", 32'(req_ready), 0);
        check("rr_issue_wr", 32'(wr_en), 0);
        check("rr_issue_rd", 32'(rd_en), ((i - 1) / 2) % 2 == 0 ? 2 : 0);
        check("rr_gap_undriven", 32'(rd_d), 0);
        if (i >= 3) begin
          check("rr_done", 32'(done), 1);
          check("rr_done_id", 32'(done_id), ((i - 1) / 2) % 2 == 0 ? 1 : 0);
        end
      end else begin
        check("rr_xfer_ready", 32'(req_ready), ((i - 1) / 2) % 2 == 0 ? 2 : 1);
        check("rr_xfer_wr", 32'(wr_en), ((i - 1) / 2) % 2 == 0 ? 8 : 4);
        check("rr_xfer_done", 32'(done), 0);
        if (((i - 1) / 2) % 2 == 1) check("rr_imm_bus", 32'(bus), 32'h77);
        if (i == 8) req_valid = '0;
      end
    end
    step;
    check("rr_last_done", 32'(done), 1);
    check("rr_last_id", 32'(done_id), 1);
    check("rr_r3", 32'(regs[3]), 32'h5A);
    check("rr_r2", 32'(regs[2]), 32'h77);
    step;
    check("rr_idle", 32'(busy), 0);
    do_move(1, 0, 4, 8'h00, 8'h10);
    do_move(0, 3, 1, 8'h00, 8'h5A);
    req_src[2:0] = 3'd3;
    req_dst[2:0] = 3'd1;
    req_valid = 2'b01;
    step;
    req_valid = '0;
    step;
    check("mid_xfer_wr", 32'(wr_en), 2);
    reset = 1'b1;
    req_valid = 2'b11;
    step;
    check("mid_rst_rd", 32'(rd_en), 0);
    check("mid_rst_wr", 32'(wr_en), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_err", 32'(err), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ready", 32'(req_ready), 0);
    reset = 1'b0;
    #1;
    check("post_rst_grant", 32'(req_ready), 1);
    for (int i = 0; i < 300; i++) begin
      step;
      req_valid = 2'($urandom_range(0, 3));
      req_src = {3'($urandom_range(0, 4)), 3'($urandom_range(0, 4))};
      req_dst = {3'($urandom_range(0, 4)), 3'($urandom_range(0, 4))};
      req_imm = 16'($urandom);
    end
    req_valid = '0;
    repeat (4) step;
    check("drain_idle", 32'(busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
